// File: rtl/frog_game_state.sv
// frog_game_state: once per video frame, scan the four car rectangles against
// the player rectangle, then run the play / hit / win / game-over flow.
// Outputs are lives, level, collide and a one-cycle respawn pulse.
// Optional feature macro: FROG_GAME_INVULN_EN. When it is defined, each respawn
// gives INVULN_FRAMES frames of invulnerability against collisions.
module frog_game_state #(
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_H      = 16,
  parameter int CAR_W         = 32,
  parameter int CAR_H         = 16,
  parameter int LIVES         = 3,
  parameter int GOAL_Y        = 288,
  parameter int PAUSE_FRAMES  = 60,
  parameter int INVULN_FRAMES = 90
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [39:0] car_x_all,
  input  logic [39:0] car_y_all,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic        respawn,
  output logic        collide,
  output logic        invuln
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  // One width serves both frame counters (pause and invulnerability).
  localparam int FRAME_MAX = (PAUSE_FRAMES > INVULN_FRAMES) ? PAUSE_FRAMES : INVULN_FRAMES;
  localparam int CNT_W     = $clog2(FRAME_MAX + 1);

  logic [2:0]       r_state;
  logic [1:0]       r_lives;
  logic [3:0]       r_level;
  logic             r_respawn;
  logic             r_collide;
  logic             r_start_q;
  logic             r_scan_busy;
  logic [1:0]       r_scan_idx;
  logic             r_scan_acc;
  logic [CNT_W-1:0] r_pause_cnt;

  logic [2:0]       w_state_nxt;
  logic [1:0]       w_lives_nxt;
  logic [3:0]       w_level_nxt;
  logic             w_enter_play;
  logic             w_new_game;
  logic             w_go_hit;
  logic             w_go_win;
  logic             w_start_edge;
  logic             w_scan_done;
  logic             w_scan_hit;
  logic             w_pause_end;
  logic             w_overlap;
  logic [9:0]       w_cx;
  logic [9:0]       w_cy;
  logic             w_invuln;

  assign w_start_edge = start & ~r_start_q;
  assign w_scan_done  = r_scan_busy && (r_scan_idx == 2'd3);
  assign w_scan_hit   = r_scan_acc | w_overlap;
  assign w_pause_end  = frame_tick && (r_pause_cnt == CNT_W'(PAUSE_FRAMES - 1));

  // Select the car under test and check rectangle overlap in 11 bits (no wrap at 1023).
  always_comb begin
    w_cx = car_x_all[9:0];
    w_cy = car_y_all[9:0];
    case (r_scan_idx)
      2'd1:    begin w_cx = car_x_all[19:10]; w_cy = car_y_all[19:10]; end
      2'd2:    begin w_cx = car_x_all[29:20]; w_cy = car_y_all[29:20]; end
      2'd3:    begin w_cx = car_x_all[39:30]; w_cy = car_y_all[39:30]; end
      default: begin w_cx = car_x_all[9:0];   w_cy = car_y_all[9:0];   end
    endcase
    w_overlap = ({1'b0, player_x} < ({1'b0, w_cx} + 11'(CAR_W)))    &&
                ({1'b0, w_cx}     < ({1'b0, player_x} + 11'(PLAYER_W))) &&
                ({1'b0, player_y} < ({1'b0, w_cy} + 11'(CAR_H)))    &&
                ({1'b0, w_cy}     < ({1'b0, player_y} + 11'(PLAYER_H)));
  end

  // Register the start button for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_start_q <= 1'b0;
    else        r_start_q <= start;
  end

  // Four-cycle car scan launched by frame_tick in PLAY; ticks during a scan are dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_scan_busy <= 1'b0;
      r_scan_idx  <= 2'd0;
      r_scan_acc  <= 1'b0;
    end else if (r_scan_busy) begin
      r_scan_acc <= w_scan_hit;
      r_scan_idx <= r_scan_idx + 2'd1;
      if (r_scan_idx == 2'd3) r_scan_busy <= 1'b0;
    end else if (frame_tick && (r_state == S_PLAY)) begin
      r_scan_busy <= 1'b1;
      r_scan_idx  <= 2'd0;
      r_scan_acc  <= 1'b0;
    end
  end

`ifdef FROG_GAME_INVULN_EN
  logic [CNT_W-1:0] r_inv_cnt;
  logic             r_invuln;

  // Invulnerability window: reload on respawn, count frames in PLAY, flag trails counter by a cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inv_cnt <= '0;
      r_invuln  <= 1'b0;
    end else if (w_enter_play) begin
      r_inv_cnt <= CNT_W'(INVULN_FRAMES);
      r_invuln  <= 1'b1;
    end else begin
      if (frame_tick && (r_state == S_PLAY) && (r_inv_cnt != '0))
        r_inv_cnt <= r_inv_cnt - CNT_W'(1);
      r_invuln <= (r_inv_cnt != '0);
    end
  end

  assign w_invuln = r_invuln;
`else
  assign w_invuln = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; collision outranks reaching the goal.
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_play = 1'b0;
    w_new_game   = 1'b0;
    w_go_hit     = 1'b0;
    w_go_win     = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt  = S_PLAY;
          w_enter_play = 1'b1;
          w_new_game   = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_scan_done) begin
          if (w_scan_hit && !w_invuln) begin
            w_state_nxt = S_HIT;
            w_go_hit    = 1'b1;
          end else if (player_y <= 10'(GOAL_Y)) begin
            w_state_nxt = S_WIN;
            w_go_win    = 1'b1;
          end
        end
      end
      S_HIT: begin
        if (w_pause_end) begin
          if (r_lives == 2'd0) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt  = S_PLAY;
            w_enter_play = 1'b1;
          end
        end
      end
      S_WIN: begin
        if (w_pause_end) begin
          w_state_nxt  = S_PLAY;
          w_enter_play = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next lives and level for the transition being taken.
  always_comb begin
    w_lives_nxt = r_lives;
    w_level_nxt = r_level;
    if (w_new_game) begin
      w_lives_nxt = 2'(LIVES);
      w_level_nxt = 4'd0;
    end else if (w_go_hit) begin
      w_lives_nxt = r_lives - 2'd1;
    end else if (w_go_win && (r_level != 4'd15)) begin
      w_level_nxt = r_level + 4'd1;
    end
  end

  // Registered game outputs: lives, level, respawn pulse, last scan result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lives   <= 2'(LIVES);
      r_level   <= 4'd0;
      r_respawn <= 1'b0;
      r_collide <= 1'b0;
    end else begin
      r_lives   <= w_lives_nxt;
      r_level   <= w_level_nxt;
      r_respawn <= w_enter_play;
      if (w_scan_done) r_collide <= w_scan_hit;
    end
  end

  // Pause counter counts frame ticks in HIT/WIN and clears on every state change.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_pause_cnt <= '0;
    else if (w_state_nxt != r_state)
      r_pause_cnt <= '0;
    else if (((r_state == S_HIT) || (r_state == S_WIN)) && frame_tick)
      r_pause_cnt <= r_pause_cnt + CNT_W'(1);
  end

  assign state   = r_state;
  assign lives   = r_lives;
  assign level   = r_level;
  assign respawn = r_respawn;
  assign collide = r_collide;
  assign invuln  = w_invuln;

endmodule

// File: tb/tb_frog_game_state.sv
// Testbench for frog_game_state: directed scenarios, a frame-level behavioural
// model compared against the DUT every cycle, and hand-computed literal checks.
`timescale 1ns/1ps
module tb_frog_game_state;

  localparam int PLAYER_W = 16, PLAYER_H = 16, CAR_W = 32, CAR_H = 16;
  localparam int LIVES = 3, GOAL_Y = 288, PAUSE_FRAMES = 60, INVULN_FRAMES = 90;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_HIT = 2, ST_WIN = 3, ST_OVER = 4;
`ifdef FROG_GAME_INVULN_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        CLK = 1'b0, RST_N = 1'b1, frame_tick = 1'b0, start = 1'b0;
  logic [9:0]  player_x = '0, player_y = '0;
  logic [39:0] car_x_all = '0, car_y_all = '0;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [3:0]  level;
  logic        respawn, collide, invuln;

  frog_game_state #(
    .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .CAR_W(CAR_W), .CAR_H(CAR_H),
    .LIVES(LIVES), .GOAL_Y(GOAL_Y), .PAUSE_FRAMES(PAUSE_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick), .start(start),
    .player_x(player_x), .player_y(player_y), .car_x_all(car_x_all), .car_y_all(car_y_all),
    .state(state), .lives(lives), .level(level), .respawn(respawn),
    .collide(collide), .invuln(invuln)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = ST_IDLE, m_lives = LIVES, m_level = 0, m_scan = -1, m_pause = 0, m_inv_cnt = 0;
  bit m_respawn = 1'b0, m_collide = 1'b0, m_inv = 1'b0, m_acc = 1'b0, m_start_q = 1'b0;

  function automatic bit overlaps(input int k);
    int px, py, cx, cy;
    px = int'(player_x);
    py = int'(player_y);
    cx = int'(car_x_all[10*k +: 10]);
    cy = int'(car_y_all[10*k +: 10]);
    return (px < cx + CAR_W) && (cx < px + PLAYER_W) && (py < cy + CAR_H) && (cy < py + PLAYER_H);
  endfunction

  always @(posedge CLK or negedge RST_N) begin : model
    int s, lv, lvl, sc, pc, ic;
    bit acc, col, inv, rs, st_edge;
    if (!RST_N) begin
      m_state <= ST_IDLE; m_lives <= LIVES; m_level <= 0; m_scan <= -1; m_pause <= 0;
      m_inv_cnt <= 0; m_respawn <= 1'b0; m_collide <= 1'b0; m_inv <= 1'b0;
      m_acc <= 1'b0; m_start_q <= 1'b0;
    end else begin
      s = m_state; lv = m_lives; lvl = m_level; sc = m_scan; pc = m_pause; ic = m_inv_cnt;
      acc = m_acc; col = m_collide; inv = m_inv; rs = 1'b0;
      st_edge = start && !m_start_q;
      if (INV_EN) begin
        inv = (m_inv_cnt != 0);
        if (frame_tick && m_state == ST_PLAY && ic > 0) ic = ic - 1;
      end
      case (m_state)
        ST_IDLE, ST_OVER: if (st_edge) begin s = ST_PLAY; lv = LIVES; lvl = 0; rs = 1'b1; end
        ST_PLAY: if (m_scan == 3) begin
          col = m_acc || overlaps(3);
          if (col && !m_inv) begin s = ST_HIT; lv = lv - 1; end
          else if (int'(player_y) <= GOAL_Y) begin s = ST_WIN; lvl = (lvl < 15) ? lvl + 1 : 15; end
        end
        ST_HIT, ST_WIN: if (frame_tick) begin
          pc = pc + 1;
          if (pc == PAUSE_FRAMES) begin
            if (m_state == ST_HIT && lv == 0) s = ST_OVER;
            else begin s = ST_PLAY; rs = 1'b1; end
          end
        end
        default: ;
      endcase
      if (sc >= 0) begin
        acc = acc || overlaps(sc);
        sc = (sc == 3) ? -1 : sc + 1;
      end else if (m_state == ST_PLAY && frame_tick) begin
        sc = 0; acc = 1'b0;
      end
      if (s != m_state) pc = 0;
      if (rs && INV_EN) begin ic = INVULN_FRAMES; inv = 1'b1; end
      m_state <= s; m_lives <= lv; m_level <= lvl; m_scan <= sc; m_pause <= pc;
      m_inv_cnt <= ic; m_respawn <= rs; m_collide <= col; m_inv <= inv;
      m_acc <= acc; m_start_q <= start;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_state",   32'(state),   32'(m_state));
      chk("cyc_lives",   32'(lives),   32'(m_lives));
      chk("cyc_level",   32'(level),   32'(m_level));
      chk("cyc_respawn", 32'(respawn), 32'(m_respawn));
      chk("cyc_collide", 32'(collide), 32'(m_collide));
      chk("cyc_invuln",  32'(invuln),  32'(m_inv));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_car(input int k, input int x, input int y);
    car_x_all[10*k +: 10] = 10'(x);
    car_y_all[10*k +: 10] = 10'(y);
  endtask

  task automatic cars_away();
    for (int k = 0; k < 4; k++) set_car(k, 600, 0);
  endtask

  // One-cycle frame_tick; returns in the cycle after the tick.
  task automatic tick();
    @(negedge CLK); frame_tick = 1'b1;
    @(negedge CLK); frame_tick = 1'b0;
  endtask

  // Tick plus full scan latency; returns in the cycle the scan result is visible.
  task automatic frame();
    tick();
    cyc(4);
  endtask

  // Count out a pause; returns in the cycle after the last counted tick.
  task automatic finish_pause();
    for (int i = 0; i < PAUSE_FRAMES - 1; i++) begin tick(); cyc(1); end
    tick();
  endtask

  task automatic press();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  // ---------------- directed scenario ----------------
  initial begin
    cars_away();
    player_x = 10'd100;
    player_y = 10'd400;
    @(posedge CLK); #2 RST_N = 1'b0;
    cmp_en = 1'b1;
    cyc(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_level", 32'(level), 0);
    chk("rst_respawn", 32'(respawn), 0);
    chk("rst_collide", 32'(collide), 0);
    chk("rst_invuln", 32'(invuln), 0);
    @(posedge CLK); #2 RST_N = 1'b1;
    cyc(3);
    chk("rel_state", 32'(state), 0);
    chk("rel_respawn", 32'(respawn), 0);

`ifdef FROG_GAME_INVULN_EN
    player_y = 10'd320;
    set_car(2, 90, 318);
    press();
    chk("inv_start_state", 32'(state), 1);
    chk("inv_start_flag", 32'(invuln), 1);
    for (int i = 0; i < INVULN_FRAMES - 1; i++) frame();
    chk("inv_hold_state", 32'(state), 1);
    chk("inv_hold_flag", 32'(invuln), 1);
    chk("inv_hold_collide", 32'(collide), 1);
    frame();
    chk("inv_hit_state", 32'(state), 2);
    chk("inv_hit_lives", 32'(lives), 2);
    chk("inv_hit_flag", 32'(invuln), 0);
`else
    press();
    chk("start_state", 32'(state), 1);
    chk("start_lives", 32'(lives), 3);
    chk("start_level", 32'(level), 0);
    chk("start_respawn", 32'(respawn), 1);
    cyc(1);
    chk("start_respawn_low", 32'(respawn), 0);
    frame();
    chk("clear_state", 32'(state), 1);
    chk("clear_collide", 32'(collide), 0);

    // car 2 at (90,318) overlaps player at (100,320)
    player_y = 10'd320;
    set_car(2, 90, 318);
    frame();
    chk("hit1_collide", 32'(collide), 1);
    chk("hit1_state", 32'(state), 2);
    chk("hit1_lives", 32'(lives), 2);
    cars_away();
    press();
    chk("hit1_start_ignored", 32'(state), 2);
    finish_pause();
    chk("hit1_resume_state", 32'(state), 1);
    chk("hit1_resume_respawn", 32'(respawn), 1);
    cyc(1);
    chk("hit1_respawn_low", 32'(respawn), 0);

    // px == cx+CAR_W is just clear; one pixel closer collides
    set_car(0, 68, 320);
    frame();
    chk("edge68_state", 32'(state), 1);
    chk("edge68_collide", 32'(collide), 0);
    set_car(0, 69, 320);
    frame();
    chk("edge69_collide", 32'(collide), 1);
    chk("edge69_state", 32'(state), 2);
    chk("edge69_lives", 32'(lives), 1);
    cars_away();
    finish_pause();
    chk("hit2_resume_state", 32'(state), 1);

    // start ignored in PLAY; second tick during a busy scan is dropped
    press();
    chk("play_start_ignored", 32'(state), 1);
    tick();
    tick();
    set_car(0, 100, 320);
    cyc(6);
    cars_away();
    chk("busy_tick_state", 32'(state), 1);
    chk("busy_tick_collide", 32'(collide), 0);

    // goal reached repeatedly; level saturates at 15
    player_y = 10'd288;
    for (int i = 0; i < 16; i++) begin
      frame();
      chk("win_state", 32'(state), 3);
      chk("win_level", 32'(level), (i < 15) ? i + 1 : 15);
      finish_pause();
      chk("win_resume_respawn", 32'(respawn), 1);
    end
    chk("win_sat_level", 32'(level), 15);

    // collision outranks goal; last life lost leads to OVER
    set_car(1, 100, 288);
    frame();
    chk("hit3_state", 32'(state), 2);
    chk("hit3_lives", 32'(lives), 0);
    chk("hit3_level", 32'(level), 15);
    cars_away();
    finish_pause();
    chk("over_state", 32'(state), 4);
    chk("over_respawn", 32'(respawn), 0);
    frame();
    chk("over_hold", 32'(state), 4);
    press();
    chk("restart_state", 32'(state), 1);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_level", 32'(level), 0);
    chk("restart_respawn", 32'(respawn), 1);

    // reset in the middle of a scan
    player_y = 10'd400;
    tick();
    cyc(1);
    @(posedge CLK); #2 RST_N = 1'b0;
    cyc(1);
    chk("midrst_state", 32'(state), 0);
    chk("midrst_lives", 32'(lives), 3);
    chk("midrst_collide", 32'(collide), 0);
    @(posedge CLK); #2 RST_N = 1'b1;
    cyc(6);
    chk("midrst_rel_state", 32'(state), 0);
    chk("midrst_rel_respawn", 32'(respawn), 0);
`endif

    cyc(2);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
